mycpu_ex_div_ctrl: RTL and testbench
====================================

// Module: mycpu_ex_div_ctrl
// PURPOSE
//  EX-stage sequencer for the myCPU 5-stage pipeline. Owns the EX valid bit and the
//  ID->EX->MEM valid/allowin handshake. Runs MIPS DIV/DIVU on an iterative radix-2
//  restoring divider and stalls EX until the quotient and remainder are ready.
//  Single-cycle ALU ops pass through in one cycle. Results feed the HI/LO write
//  logic alongside the EX/MEM pipeline register.
// PARAMETERS
//  DIV_WIDTH  32  operand/result width; iteration count = DIV_WIDTH
// PORTS
//  clk              in   1          clock, rising edge
//  rst              in   1          async reset, active-high
//  id_to_ex_valid   in   1          ID holds a valid instruction for EX
//  ex_allowin       out  1          EX accepts from ID this cycle
//  ex_div_op        in   1          current EX inst is DIV/DIVU (from EX pipe reg)
//  ex_div_signed    in   1          1=DIV, 0=DIVU
//  ex_src_a         in   DIV_WIDTH  dividend (held stable by EX pipe reg during stall)
//  ex_src_b         in   DIV_WIDTH  divisor
//  mem_allowin      in   1          MEM accepts from EX this cycle
//  flush            in   1          exception/redirect: kill EX inst, abort divide
//  ex_to_mem_valid  out  1          EX inst valid and ready to move to MEM
//  div_quot         out  DIV_WIDTH  quotient (to LO), valid when div_done
//  div_rem          out  DIV_WIDTH  remainder (to HI), valid when div_done
//  div_done         out  1          state==DONE
//  div_busy         out  1          state==RUN
// BEHAVIOUR
//  Reset: ex_valid=0, state=IDLE, count=0, div_quot=0, div_rem=0; all outputs 0
//   except ex_allowin=1.
//  Handshake:
//   ex_ready_go = !ex_div_op | (state==DONE).
//   ex_allowin = !ex_valid | (ex_ready_go & mem_allowin).
//   ex_to_mem_valid = ex_valid & ex_ready_go & !flush.
//   ex_valid update: flush -> 0; else if ex_allowin -> id_to_ex_valid; else hold.
//  FSM IDLE/RUN/DONE:
//   IDLE->RUN: ex_valid & ex_div_op & !flush & ex_src_b!=0.
//    - Latch |a| and |b| (two's-complement abs when signed, raw when unsigned).
//    - Latch q_neg = signed & (a[MSB]^b[MSB]) and r_neg = signed & a[MSB].
//    - Clear the partial remainder; count=0.
//   IDLE->DONE: same entry condition but ex_src_b==0.
//    - Divide-by-zero result: quot = all-ones, rem = ex_src_a; no iterations.
//   RUN: one restoring step per cycle.
//    - Shift {rem,dividend} left by 1; trial-subtract divisor.
//    - If no borrow, keep the difference and set the quotient bit.
//    - count++; at count==DIV_WIDTH-1 the final step completes and state->DONE.
//   DONE:
//    - Apply signs: quot negated if q_neg, rem negated if r_neg.
//    - div_quot/div_rem stay stable for the whole DONE state.
//    - DONE->IDLE when mem_allowin (the instruction leaves EX).
//   Back-to-back divides: the next div is accepted in IDLE the cycle after DONE exits.
//  Latency: divide valid in EX at cycle 0 -> div_done and ex_to_mem_valid high at
//   cycle DIV_WIDTH+1 (33 default); /0 -> cycle 1. Non-div ops: ready_go same cycle.
//  Overflow: signed 0x80000000 / -1 -> quot 0x80000000, rem 0; no exception raised.
//  flush: dominates everything. In any state -> IDLE and count=0 next cycle.
//   ex_valid=0; div_quot/div_rem hold their last values. No partial result leaves EX.
//  mem_allowin=0 in DONE: stay in DONE, results held, ex_allowin=0.
//  Reset mid-divide: immediate return to reset values (async).
// TESTING
//  DIVU 100/7, mem_allowin=1 -> ex_to_mem_valid 33 cycles after EX valid; quot=14, rem=2; ex_allowin=0 throughout RUN.
//  DIV -7/2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF -> quot=0x80000000, rem=0.
//  DIVU 5/0 -> div_done 1 cycle after EX valid; quot=0xFFFFFFFF, rem=5.
//  ADD stream, mem_allowin toggling 1,0,1 -> ex_valid held while mem_allowin=0; no inst dropped or duplicated.
//  flush at RUN count=10 -> IDLE next cycle, ex_to_mem_valid never asserted; following DIVU 9/3 -> 3 rem 0.
//  DIVU completes with mem_allowin=0 for 5 cycles -> DONE held, results stable, exit on first mem_allowin=1; async rst mid-RUN -> all outputs reset immediately.

Source files
------------

// File: rtl/mycpu_ex_div_ctrl_if.sv
// EX-stage handshake and divider result bundle between the pipeline and the
// EX divide sequencer. The slave modport is the sequencer side.
interface mycpu_ex_div_ctrl_if #(
  parameter int DIV_WIDTH = 32
);

  logic                 id_to_ex_valid;
  logic                 ex_allowin;
  logic                 ex_div_op;
  logic                 ex_div_signed;
  logic [DIV_WIDTH-1:0] ex_src_a;
  logic [DIV_WIDTH-1:0] ex_src_b;
  logic                 mem_allowin;
  logic                 flush;
  logic                 ex_to_mem_valid;
  logic [DIV_WIDTH-1:0] div_quot;
  logic [DIV_WIDTH-1:0] div_rem;
  logic                 div_done;
  logic                 div_busy;

  modport master (
    output id_to_ex_valid, ex_div_op, ex_div_signed, ex_src_a, ex_src_b,
           mem_allowin, flush,
    input  ex_allowin, ex_to_mem_valid, div_quot, div_rem, div_done, div_busy
  );

  modport slave (
    input  id_to_ex_valid, ex_div_op, ex_div_signed, ex_src_a, ex_src_b,
           mem_allowin, flush,
    output ex_allowin, ex_to_mem_valid, div_quot, div_rem, div_done, div_busy
  );

endinterface

// File: rtl/mycpu_ex_div_ctrl.sv
// EX-stage sequencer: owns the EX valid bit and the ID->EX->MEM handshake,
// and stalls EX while an iterative radix-2 restoring divider runs DIV/DIVU.
module mycpu_ex_div_ctrl #(
  parameter int DIV_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  mycpu_ex_div_ctrl_if.slave bus
);

  localparam int CW = $clog2(DIV_WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q;
  logic                 ex_valid_q;
  logic [CW-1:0]        count_q;
  logic [DIV_WIDTH-1:0] dvd_q;
  logic [DIV_WIDTH-1:0] dsr_q;
  logic [DIV_WIDTH-1:0] rem_q;
  logic                 q_neg_q;
  logic                 r_neg_q;
  logic [DIV_WIDTH-1:0] quot_q;
  logic [DIV_WIDTH-1:0] rem_out_q;

  logic                 ready_go;
  logic                 div_start;
  logic                 a_neg;
  logic                 b_neg;
  logic [DIV_WIDTH-1:0] abs_a_d;
  logic [DIV_WIDTH-1:0] abs_b_d;
  logic [DIV_WIDTH:0]   shifted_d;
  logic [DIV_WIDTH:0]   diff_d;
  logic                 qbit_d;
  logic [DIV_WIDTH-1:0] dvd_d;
  logic [DIV_WIDTH-1:0] rem_d;
  logic [DIV_WIDTH-1:0] quot_fin_d;
  logic [DIV_WIDTH-1:0] rem_fin_d;

  assign ready_go            = !bus.ex_div_op | (state_q == DONE);
  assign bus.ex_allowin      = !ex_valid_q | (ready_go & bus.mem_allowin);
  assign bus.ex_to_mem_valid = ex_valid_q & ready_go & !bus.flush;
  assign div_start           = ex_valid_q & bus.ex_div_op & !bus.flush;

  assign a_neg   = bus.ex_div_signed & bus.ex_src_a[DIV_WIDTH-1];
  assign b_neg   = bus.ex_div_signed & bus.ex_src_b[DIV_WIDTH-1];
  assign abs_a_d = a_neg ? -bus.ex_src_a : bus.ex_src_a;
  assign abs_b_d = b_neg ? -bus.ex_src_b : bus.ex_src_b;

  // One restoring step: the partial remainder is always below the divisor,
  // so after the trial subtract it fits back into DIV_WIDTH bits.
  assign shifted_d  = {rem_q, dvd_q[DIV_WIDTH-1]};
  assign diff_d     = shifted_d - {1'b0, dsr_q};
  assign qbit_d     = shifted_d >= {1'b0, dsr_q};
  assign rem_d      = qbit_d ? diff_d[DIV_WIDTH-1:0] : shifted_d[DIV_WIDTH-1:0];
  assign dvd_d      = {dvd_q[DIV_WIDTH-2:0], qbit_d};
  assign quot_fin_d = q_neg_q ? -dvd_d : dvd_d;
  assign rem_fin_d  = r_neg_q ? -rem_d : rem_d;

  assign bus.div_quot = quot_q;
  assign bus.div_rem  = rem_out_q;
  assign bus.div_done = (state_q == DONE);
  assign bus.div_busy = (state_q == RUN);

  // Sign-corrected results are written on the last step, so they are already
  // final and stable for every cycle spent in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ex_valid_q <= 1'b0;
      count_q    <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      quot_q     <= '0;
      rem_out_q  <= '0;
    end else begin
      if (bus.flush) begin
        ex_valid_q <= 1'b0;
      end else if (bus.ex_allowin) begin
        ex_valid_q <= bus.id_to_ex_valid;
      end

      if (bus.flush) begin
        state_q <= IDLE;
        count_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (div_start) begin
              if (bus.ex_src_b == '0) begin
                quot_q    <= '1;
                rem_out_q <= bus.ex_src_a;
                state_q   <= DONE;
              end else begin
                dvd_q   <= abs_a_d;
                dsr_q   <= abs_b_d;
                rem_q   <= '0;
                q_neg_q <= a_neg ^ b_neg;
                r_neg_q <= a_neg;
                count_q <= '0;
                state_q <= RUN;
              end
            end
          end
          RUN: begin
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST_STEP) begin
              quot_q    <= quot_fin_d;
              rem_out_q <= rem_fin_d;
              count_q   <= '0;
              state_q   <= DONE;
            end
          end
          DONE: begin
            if (bus.mem_allowin) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mycpu_ex_div_ctrl.sv
// Directed bench for the EX divide sequencer: divide results and latency,
// handshake stalls, flush abort and asynchronous reset.
module tb_mycpu_ex_div_ctrl;

  logic clk;
  logic rst;
  int   numChecks;
  int   numErrors;
  int   cycles;

  mycpu_ex_div_ctrl_if #(.DIV_WIDTH(32)) dutIf ();

  mycpu_ex_div_ctrl #(.DIV_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dutIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic idValid, input logic divOp,
                               input logic divSigned, input logic [31:0] a,
                               input logic [31:0] b, input logic memAllow,
                               input logic fl);
    dutIf.id_to_ex_valid = idValid;
    dutIf.ex_div_op      = divOp;
    dutIf.ex_div_signed  = divSigned;
    dutIf.ex_src_a       = a;
    dutIf.ex_src_b       = b;
    dutIf.mem_allowin    = memAllow;
    dutIf.flush          = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one divide from an empty EX and waits (bounded) for DONE;
  // returns the number of cycles from EX-valid to div_done.
  task automatic runDiv(input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic memAllow,
                        output int nCycles);
    applyStimulus(1'b1, 1'b1, sgn, a, b, memAllow, 1'b0);
    tick();
    dutIf.id_to_ex_valid = 1'b0;
    #1;
    nCycles = 0;
    while (!dutIf.div_done && nCycles < 100) begin
      checkOutput("allowin_stall", 32'(dutIf.ex_allowin), 32'd0);
      checkOutput("tomem_stall", 32'(dutIf.ex_to_mem_valid), 32'd0);
      tick();
      nCycles++;
    end
  endtask

  typedef struct {
    logic idValid;
    logic memAllow;
    logic expAllowin;
    logic expToMem;
  } addVec_t;

  addVec_t addVecs[6];

  initial begin
    numChecks = 0;
    numErrors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    checkOutput("rst_allowin", 32'(dutIf.ex_allowin), 32'd1);
    checkOutput("rst_tomem", 32'(dutIf.ex_to_mem_valid), 32'd0);
    checkOutput("rst_done", 32'(dutIf.div_done), 32'd0);
    checkOutput("rst_busy", 32'(dutIf.div_busy), 32'd0);
    checkOutput("rst_quot", dutIf.div_quot, 32'd0);
    checkOutput("rst_rem", dutIf.div_rem, 32'd0);
    rst = 1'b0;
    tick();

    runDiv(1'b0, 32'd100, 32'd7, 1'b1, cycles);
    checkOutput("divu100_lat", 32'(cycles), 32'd33);
    checkOutput("divu100_tomem", 32'(dutIf.ex_to_mem_valid), 32'd1);
    checkOutput("divu100_allowin", 32'(dutIf.ex_allowin), 32'd1);
    checkOutput("divu100_quot", dutIf.div_quot, 32'd14);
    checkOutput("divu100_rem", dutIf.div_rem, 32'd2);
    tick();
    checkOutput("divu100_exit", 32'(dutIf.div_done), 32'd0);
    checkOutput("divu100_gone", 32'(dutIf.ex_to_mem_valid), 32'd0);

    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, cycles);
    checkOutput("div_m7_lat", 32'(cycles), 32'd33);
    checkOutput("div_m7_quot", dutIf.div_quot, 32'hFFFF_FFFD);
    checkOutput("div_m7_rem", dutIf.div_rem, 32'hFFFF_FFFF);
    tick();

    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cycles);
    checkOutput("div_ovf_lat", 32'(cycles), 32'd33);
    checkOutput("div_ovf_quot", dutIf.div_quot, 32'h8000_0000);
    checkOutput("div_ovf_rem", dutIf.div_rem, 32'd0);
    tick();

    runDiv(1'b0, 32'd5, 32'd0, 1'b1, cycles);
    checkOutput("div0_lat", 32'(cycles), 32'd1);
    checkOutput("div0_tomem", 32'(dutIf.ex_to_mem_valid), 32'd1);
    checkOutput("div0_quot", dutIf.div_quot, 32'hFFFF_FFFF);
    checkOutput("div0_rem", dutIf.div_rem, 32'd5);
    tick();
    checkOutput("div0_exit", 32'(dutIf.div_done), 32'd0);

    addVecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0};
    addVecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1};
    addVecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1};
    addVecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    addVecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    addVecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(addVecs[i].idValid, 1'b0, 1'b0, 32'd1, 32'd2,
                    addVecs[i].memAllow, 1'b0);
      #1;
      checkOutput($sformatf("add%0d_allowin", i), 32'(dutIf.ex_allowin),
                  32'(addVecs[i].expAllowin));
      checkOutput($sformatf("add%0d_tomem", i), 32'(dutIf.ex_to_mem_valid),
                  32'(addVecs[i].expToMem));
      tick();
    end

    applyStimulus(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    tick();
    dutIf.id_to_ex_valid = 1'b0;
    repeat (11) tick();
    checkOutput("flush_busy", 32'(dutIf.div_busy), 32'd1);
    dutIf.flush = 1'b1;
    #1;
    checkOutput("flush_tomem", 32'(dutIf.ex_to_mem_valid), 32'd0);
    tick();
    dutIf.flush = 1'b0;
    #1;
    checkOutput("flush_idle", 32'(dutIf.div_busy), 32'd0);
    checkOutput("flush_quot_hold", dutIf.div_quot, 32'hFFFF_FFFF);
    checkOutput("flush_rem_hold", dutIf.div_rem, 32'd5);
    for (int i = 0; i < 3; i++) begin
      checkOutput("flush_nodone", 32'(dutIf.div_done), 32'd0);
      checkOutput("flush_notomem", 32'(dutIf.ex_to_mem_valid), 32'd0);
      tick();
    end

    runDiv(1'b0, 32'd9, 32'd3, 1'b1, cycles);
    checkOutput("divu9_lat", 32'(cycles), 32'd33);
    checkOutput("divu9_quot", dutIf.div_quot, 32'd3);
    checkOutput("divu9_rem", dutIf.div_rem, 32'd0);
    tick();

    runDiv(1'b0, 32'd50, 32'd6, 1'b0, cycles);
    checkOutput("stall_lat", 32'(cycles), 32'd33);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_done", 32'(dutIf.div_done), 32'd1);
      checkOutput("stall_allowin", 32'(dutIf.ex_allowin), 32'd0);
      checkOutput("stall_tomem", 32'(dutIf.ex_to_mem_valid), 32'd1);
      checkOutput("stall_quot", dutIf.div_quot, 32'd8);
      checkOutput("stall_rem", dutIf.div_rem, 32'd2);
      tick();
    end
    dutIf.mem_allowin = 1'b1;
    #1;
    checkOutput("stall_release", 32'(dutIf.ex_allowin), 32'd1);
    tick();
    checkOutput("stall_exit", 32'(dutIf.div_done), 32'd0);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    tick();
    dutIf.id_to_ex_valid = 1'b0;
    repeat (5) tick();
    checkOutput("mrst_busy_before", 32'(dutIf.div_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mrst_busy", 32'(dutIf.div_busy), 32'd0);
    checkOutput("mrst_done", 32'(dutIf.div_done), 32'd0);
    checkOutput("mrst_allowin", 32'(dutIf.ex_allowin), 32'd1);
    checkOutput("mrst_tomem", 32'(dutIf.ex_to_mem_valid), 32'd0);
    checkOutput("mrst_quot", dutIf.div_quot, 32'd0);
    checkOutput("mrst_rem", dutIf.div_rem, 32'd0);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("mrst_stay_idle", 32'(dutIf.div_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
